// File: rtl/instruction_fetch_unit_if.sv
// instruction_fetch_unit_if: instruction-memory read handshake between the fetch unit and memory.
//   imem_req    master->slave  read request, held until accepted
//   imem_addr   master->slave  word-aligned read address
//   imem_ready  slave->master  request accepted this cycle (qualified by imem_req)
//   imem_rvalid slave->master  read data valid, at least one cycle after acceptance
//   imem_rdata  slave->master  instruction word
interface instruction_fetch_unit_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic                  imem_req;
    logic [ADDR_WIDTH-1:0] imem_addr;
    logic                  imem_ready;
    logic                  imem_rvalid;
    logic [DATA_WIDTH-1:0] imem_rdata;
    modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: PC owner that fetches one word at a time and holds it until decode accepts it.
//   clk, rst          clock and synchronous active-high reset
//   fetch_en_i        permits leaving IDLE
//   stall_i           decode cannot accept the held instruction this cycle
//   redirect_i        branch taken; redirect_pc_i is the target (low two bits ignored)
//   imem              instruction-memory master port (req/ready/rvalid)
//   instr_o           held instruction word; opcode_o/v_o/funct_o/rd_o are slices of it
//   pc_out_o          address of instr_o; pc_plus4_o = pc_out_o + 4
//   instr_valid_o     instruction and fields are valid
//   fetch_error_o     sticky watchdog flag, only active when FETCH_TIMEOUT_EN is defined
module instruction_fetch_unit #(
    parameter int unsigned           ADDR_WIDTH     = 32,
    parameter int unsigned           DATA_WIDTH     = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC       = '0,
    parameter int unsigned           TIMEOUT_CYCLES = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fetch_en_i,
    input  logic                     stall_i,
    input  logic                     redirect_i,
    input  logic [ADDR_WIDTH-1:0]    redirect_pc_i,
    instruction_fetch_unit_if.master imem,
    output logic [DATA_WIDTH-1:0]    instr_o,
    output logic [2:0]               opcode_o,
    output logic                     v_o,
    output logic [2:0]               funct_o,
    output logic [3:0]               rd_o,
    output logic [ADDR_WIDTH-1:0]    pc_out_o,
    output logic [ADDR_WIDTH-1:0]    pc_plus4_o,
    output logic                     instr_valid_o,
    output logic                     fetch_error_o
);
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] REQ   = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;
    localparam logic [1:0] VALID = 2'd3;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d, pc_out_q, pc_out_d, target;
    logic [DATA_WIDTH-1:0] instr_q, instr_d;
    logic                  discard_q, discard_d, timeout, take;

    assign target        = redirect_pc_i & ~ADDR_WIDTH'(3);
    assign take          = imem.imem_rvalid & ~redirect_i & ~discard_q;
    assign imem.imem_req  = state_q == REQ;
    assign imem.imem_addr = pc_q;
    assign instr_o       = instr_q;
    assign opcode_o      = instr_q[31:29];
    assign v_o           = instr_q[28];
    assign funct_o       = instr_q[27:25];
    assign rd_o          = instr_q[19:16];
    assign pc_out_o      = pc_out_q;
    assign pc_plus4_o    = pc_out_q + ADDR_WIDTH'(4);
    assign instr_valid_o = state_q == VALID;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    logic [CW-1:0] cnt_q;
    logic          fetch_error_q;
    assign timeout       = state_q == WAIT && !imem.imem_rvalid && cnt_q == CW'(TIMEOUT_CYCLES - 1);
    assign fetch_error_o = fetch_error_q;
    // WAIT is only entered from REQ, where the counter is held at zero
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q         <= '0;
            fetch_error_q <= 1'b0;
        end else begin
            cnt_q         <= state_q == WAIT ? cnt_q + CW'(1) : '0;
            fetch_error_q <= fetch_error_q | timeout;
        end
    end
`else
    assign timeout       = 1'b0;
    assign fetch_error_o = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        pc_out_d  = pc_out_q;
        instr_d   = instr_q;
        discard_d = discard_q;
        case (state_q)
            IDLE: begin
                pc_d    = redirect_i ? target : pc_q;
                state_d = fetch_en_i ? REQ : IDLE;
            end
            REQ: begin
                pc_d      = redirect_i ? target : pc_q;
                state_d   = imem.imem_ready ? WAIT : REQ;
                // a granted request whose address was just overridden returns stale data
                discard_d = discard_q | (redirect_i & imem.imem_ready);
            end
            WAIT: begin
                pc_d      = redirect_i ? target : pc_q;
                instr_d   = take ? imem.imem_rdata : instr_q;
                pc_out_d  = take ? pc_q : pc_out_q;
                state_d   = take ? VALID : (imem.imem_rvalid | timeout) ? REQ : WAIT;
                // returning data consumes the pending discard; redirect or timeout leaves one outstanding
                discard_d = imem.imem_rvalid ? 1'b0 : discard_q | redirect_i | timeout;
            end
            default: begin
                pc_d    = redirect_i ? target : stall_i ? pc_q : pc_q + ADDR_WIDTH'(4);
                state_d = (redirect_i | ~stall_i) ? REQ : VALID;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            pc_out_q  <= RESET_PC;
            instr_q   <= '0;
            discard_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            pc_out_q  <= pc_out_d;
            instr_q   <= instr_d;
            discard_q <= discard_d;
        end
    end
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb_instruction_fetch_unit: directed scoreboard bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst, fetch_en, stall, redirect, fetch_en_b;
    logic [31:0] redirect_pc;
    logic [31:0] instr, pc_out, pc_plus4, instr_b, pc_out_b, pc_plus4_b;
    logic [2:0]  opcode, funct, opcode_b, funct_b;
    logic [3:0]  rd, rd_b;
    logic        v, instr_valid, fetch_error, v_b, instr_valid_b, fetch_error_b;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] data;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    instruction_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifa ();
    instruction_fetch_unit_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifb ();

    instruction_fetch_unit #(.RESET_PC(32'h0), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst), .fetch_en_i(fetch_en), .stall_i(stall), .redirect_i(redirect),
        .redirect_pc_i(redirect_pc), .imem(ifa.master), .instr_o(instr), .opcode_o(opcode),
        .v_o(v), .funct_o(funct), .rd_o(rd), .pc_out_o(pc_out), .pc_plus4_o(pc_plus4),
        .instr_valid_o(instr_valid), .fetch_error_o(fetch_error)
    );

    instruction_fetch_unit #(.RESET_PC(32'hFFFF_FFFC), .TIMEOUT_CYCLES(4)) dut_b (
        .clk(clk), .rst(rst), .fetch_en_i(fetch_en_b), .stall_i(1'b0), .redirect_i(1'b0),
        .redirect_pc_i(32'h0), .imem(ifb.master), .instr_o(instr_b), .opcode_o(opcode_b),
        .v_o(v_b), .funct_o(funct_b), .rd_o(rd_b), .pc_out_o(pc_out_b), .pc_plus4_o(pc_plus4_b),
        .instr_valid_o(instr_valid_b), .fetch_error_o(fetch_error_b)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; serves one request at address a and returns d one cycle after grant.
    task automatic fetch(input logic [31:0] a, input logic [31:0] d);
        int n = 0;
        while (!ifa.imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("req_seen", ifa.imem_req, 1);
        chk("req_addr", ifa.imem_addr, a);
        ifa.imem_ready = 1'b1;
        @(negedge clk);
        ifa.imem_ready  = 1'b0;
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata  = d;
        sb.push_back('{pc: a, data: d});
        @(negedge clk);
        ifa.imem_rvalid = 1'b0;
    endtask

    task automatic expect_valid();
        exp_t e;
        int n = 0;
        while (!instr_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("instr_valid", instr_valid, 1);
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=valid expected=no_instruction");
        end else begin
            e = sb.pop_front();
            chk("instr", instr, e.data);
            chk("pc_out", pc_out, e.pc);
            chk("pc_plus4", pc_plus4, e.pc + 32'd4);
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=running expected=finished");
        $fatal(1);
    end

    initial begin
        rst = 1'b1; fetch_en = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0; fetch_en_b = 1'b0;
        ifa.imem_ready = 1'b0; ifa.imem_rvalid = 1'b0; ifa.imem_rdata = '0;
        ifb.imem_ready = 1'b0; ifb.imem_rvalid = 1'b0; ifb.imem_rdata = '0;
        repeat (2) @(negedge clk);
        chk("rst_req", ifa.imem_req, 0);
        chk("rst_addr", ifa.imem_addr, 0);
        chk("rst_instr", instr, 0);
        chk("rst_opcode", opcode, 0);
        chk("rst_pc_out", pc_out, 0);
        chk("rst_pc_plus4", pc_plus4, 4);
        chk("rst_valid", instr_valid, 0);
        chk("rst_error", fetch_error, 0);
        chk("rst_b_addr", ifb.imem_addr, 32'hFFFF_FFFC);
        chk("rst_b_plus4", pc_plus4_b, 0);
        rst = 1'b0;
        fetch_en = 1'b1;
        @(negedge clk);
        // first fetch and field decode
        fetch(32'h0, 32'hA512_3456);
        expect_valid();
        chk("opcode", opcode, 5);
        chk("v", v, 0);
        chk("funct", funct, 2);
        chk("rd", rd, 2);
        @(negedge clk);
        chk("accept_drop", instr_valid, 0);
        chk("next_addr", ifa.imem_addr, 4);
        // hold under stall
        stall = 1'b1;
        fetch(32'h4, 32'h5BCD_1234);
        expect_valid();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("stall_valid", instr_valid, 1);
            chk("stall_instr", instr, 32'h5BCD_1234);
            chk("stall_pc", pc_out, 4);
            chk("stall_req", ifa.imem_req, 0);
        end
        chk("v1", v, 1);
        chk("funct5", funct, 5);
        chk("rd_d", rd, 4'hD);
        stall = 1'b0;
        @(negedge clk);
        chk("post_stall_req", ifa.imem_req, 1);
        chk("post_stall_addr", ifa.imem_addr, 8);
        // redirect during WAIT, stale data two cycles later
        ifa.imem_ready = 1'b1;
        @(negedge clk);
        ifa.imem_ready = 1'b0;
        redirect = 1'b1;
        redirect_pc = 32'h103;
        @(negedge clk);
        redirect = 1'b0;
        @(negedge clk);
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        ifa.imem_rvalid = 1'b0;
        chk("wait_redir_valid", instr_valid, 0);
        chk("wait_redir_req", ifa.imem_req, 1);
        chk("wait_redir_addr", ifa.imem_addr, 32'h100);
        // redirect in the granting REQ cycle
        ifa.imem_ready = 1'b1;
        redirect = 1'b1;
        redirect_pc = 32'h180;
        @(negedge clk);
        ifa.imem_ready = 1'b0;
        redirect = 1'b0;
        chk("grant_redir_wait", ifa.imem_req, 0);
        @(negedge clk);
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata = 32'hBAD0_0001;
        @(negedge clk);
        ifa.imem_rvalid = 1'b0;
        chk("grant_redir_valid", instr_valid, 0);
        chk("grant_redir_addr", ifa.imem_addr, 32'h180);
        // redirect in the same cycle as rvalid
        ifa.imem_ready = 1'b1;
        @(negedge clk);
        ifa.imem_ready = 1'b0;
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata = 32'hBAD0_0002;
        redirect = 1'b1;
        redirect_pc = 32'h200;
        @(negedge clk);
        ifa.imem_rvalid = 1'b0;
        redirect = 1'b0;
        chk("rv_redir_valid", instr_valid, 0);
        chk("rv_redir_req", ifa.imem_req, 1);
        chk("rv_redir_addr", ifa.imem_addr, 32'h200);
        // redirect in VALID while stalled
        stall = 1'b1;
        fetch(32'h200, 32'hC0FF_EE00);
        expect_valid();
        redirect = 1'b1;
        redirect_pc = 32'h300;
        @(negedge clk);
        chk("valid_redir_valid", instr_valid, 0);
        chk("valid_redir_addr", ifa.imem_addr, 32'h300);
        // redirect in REQ before grant
        redirect_pc = 32'h404;
        @(negedge clk);
        redirect = 1'b0;
        chk("req_redir_req", ifa.imem_req, 1);
        chk("req_redir_addr", ifa.imem_addr, 32'h404);
        stall = 1'b0;
        fetch(32'h404, 32'h1234_5678);
        expect_valid();
        @(negedge clk);
        chk("after_404", ifa.imem_addr, 32'h408);
        // reset during WAIT, late rvalid ignored
        ifa.imem_ready = 1'b1;
        @(negedge clk);
        ifa.imem_ready = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        fetch_en = 1'b0;
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata = 32'hBAD0_0003;
        @(negedge clk);
        ifa.imem_rvalid = 1'b0;
        chk("mid_rst_valid", instr_valid, 0);
        chk("mid_rst_req", ifa.imem_req, 0);
        chk("mid_rst_addr", ifa.imem_addr, 0);
        chk("mid_rst_instr", instr, 0);
        chk("mid_rst_pc_out", pc_out, 0);
        chk("mid_rst_plus4", pc_plus4, 4);
        @(negedge clk);
        chk("idle_hold", ifa.imem_req, 0);
        fetch_en = 1'b1;
        @(negedge clk);
        chk("restart_req", ifa.imem_req, 1);
        chk("restart_addr", ifa.imem_addr, 0);
`ifdef FETCH_TIMEOUT_EN
        ifa.imem_ready = 1'b1;
        @(negedge clk);
        ifa.imem_ready = 1'b0;
        chk("to_wait", ifa.imem_req, 0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("to_pending", fetch_error, 0);
            chk("to_pending_req", ifa.imem_req, 0);
        end
        @(negedge clk);
        chk("to_error", fetch_error, 1);
        chk("to_retry_req", ifa.imem_req, 1);
        chk("to_retry_addr", ifa.imem_addr, 0);
        ifa.imem_ready = 1'b1;
        @(negedge clk);
        ifa.imem_ready = 1'b0;
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata = 32'hBAD0_0004;
        @(negedge clk);
        ifa.imem_rvalid = 1'b0;
        chk("to_late_valid", instr_valid, 0);
        chk("to_late_req", ifa.imem_req, 1);
        chk("to_sticky", fetch_error, 1);
        fetch(32'h0, 32'h2000_0000);
        expect_valid();
`else
        ifa.imem_ready = 1'b1;
        @(negedge clk);
        ifa.imem_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("long_wait_req", ifa.imem_req, 0);
            chk("no_error", fetch_error, 0);
        end
        ifa.imem_rvalid = 1'b1;
        ifa.imem_rdata = 32'h2000_0000;
        sb.push_back('{pc: 32'h0, data: 32'h2000_0000});
        @(negedge clk);
        ifa.imem_rvalid = 1'b0;
        expect_valid();
`endif
        // PC wrap on the RESET_PC = 0xFFFFFFFC instance
        fetch_en_b = 1'b1;
        @(negedge clk);
        chk("b_req", ifb.imem_req, 1);
        chk("b_addr", ifb.imem_addr, 32'hFFFF_FFFC);
        ifb.imem_ready = 1'b1;
        @(negedge clk);
        ifb.imem_ready = 1'b0;
        ifb.imem_rvalid = 1'b1;
        ifb.imem_rdata = 32'h2A00_0000;
        @(negedge clk);
        ifb.imem_rvalid = 1'b0;
        chk("b_valid", instr_valid_b, 1);
        chk("b_opcode", opcode_b, 1);
        chk("b_pc_out", pc_out_b, 32'hFFFF_FFFC);
        chk("b_plus4", pc_plus4_b, 0);
        @(negedge clk);
        chk("b_wrap_req", ifb.imem_req, 1);
        chk("b_wrap_addr", ifb.imem_addr, 0);
        chk("sb_drained", sb.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage that drives the instruction fields (Opcode, V, Funct, Rd) consumed by the control-unit decoder.
- Receives the PC-source redirect produced downstream from PCS.
- Owns the PC register and fetches one instruction word at a time from instruction memory over a req/ready/rvalid handshake.
- Holds the fetched word until the decode stage accepts it.

Parameters:
- ADDR_WIDTH, 32, width of PC and instruction memory address.
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC value loaded on reset.
- TIMEOUT_CYCLES, 16, watchdog limit; only used with FETCH_TIMEOUT_EN.

Ports:
- clk  in  1  single clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- fetch_en  in  1  allows leaving IDLE.
- imem_req  out  1  read request to instruction memory.
- imem_addr  out  ADDR_WIDTH  read address; equals pc.
- imem_ready  in  1  memory accepts the request this cycle.
- imem_rvalid  in  1  read data valid; at least 1 cycle after the accepting cycle.
- imem_rdata  in  DATA_WIDTH  instruction word.
- stall  in  1  decode stage cannot accept this cycle.
- redirect  in  1  take a branch (PCS path).
- redirect_pc  in  ADDR_WIDTH  branch target.
- instr  out  DATA_WIDTH  held instruction word.
- opcode  out  3  instr[31:29].
- v  out  1  instr[28].
- funct  out  3  instr[27:25].
- rd  out  4  instr[19:16].
- pc_out  out  ADDR_WIDTH  address of instr.
- pc_plus4  out  ADDR_WIDTH  pc_out+4.
- instr_valid  out  1  instr and field outputs are valid.
- fetch_error  out  1  sticky timeout flag; 0 when FETCH_TIMEOUT_EN is not defined.

Behaviour:
- Reset values:
  - state = IDLE.
  - pc = RESET_PC.
  - instr = 0; all field outputs = 0.
  - pc_out = RESET_PC; pc_plus4 = RESET_PC+4.
  - imem_req = 0, instr_valid = 0, fetch_error = 0.
  - discard flag = 0.
- Reset asserted mid-transaction abandons it. A late imem_rvalid after reset is ignored because state is not WAIT.
- Field outputs are combinational slices of the instr register.
- imem_req is 1 only in REQ. imem_addr = pc at all times.
- States:
  - IDLE: go to REQ when fetch_en = 1.
  - REQ: imem_req = 1. If imem_ready = 1, go to WAIT. A request is accepted only in a cycle with imem_req & imem_ready.
  - WAIT: wait for imem_rvalid. When it arrives:
    - discard = 1: drop the data, clear discard, go to REQ.
    - otherwise: load instr, load pc_out = pc, go to VALID.
  - VALID: instr_valid = 1. Accept = instr_valid & ~stall. On accept:
    - pc <= pc+4; go to REQ.
    - Outputs hold while stalled; instr_valid drops the cycle after accept.
- Back-to-back throughput: one instruction per 3 cycles minimum (REQ → WAIT → VALID with 1-cycle memory latency).
- Redirect always has priority over stall and accept. redirect_pc[1:0] is forced to 00.
  - IDLE: pc <= redirect_pc.
  - REQ without imem_ready: pc <= redirect_pc; stay in REQ. The address may change before grant.
  - REQ with imem_ready in the same cycle: pc <= redirect_pc; set discard; go to WAIT.
  - WAIT: pc <= redirect_pc.
    - If imem_rvalid arrives in the same cycle: drop the data, go to REQ.
    - Otherwise: set discard.
  - VALID: drop instr (instr_valid = 0 next cycle); pc <= redirect_pc; go to REQ.
- pc+4 wraps modulo 2^ADDR_WIDTH (e.g. 0xFFFFFFFC → 0x00000000).
- fetch_en = 0 only gates IDLE → REQ. It does not abort transactions in flight.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs in WAIT and clears on entry to WAIT.
  - If TIMEOUT_CYCLES cycles pass with no imem_rvalid: fetch_error <= 1 (sticky until rst), go to REQ, and retry the same pc.
  - A late imem_rvalid for the abandoned request is ignored: the discard flag is set on timeout.
- Not defined: no counter; WAIT waits indefinitely; fetch_error is tied to 0.

Test Plan:
- Reset, fetch_en = 1, memory returns 0xA5123456 one cycle after ready → instr_valid = 1, opcode = 5, v = 0, funct = 2, rd = 2, pc_out = 0, pc_plus4 = 4; next fetch at addr 4.
- stall = 1 for 5 cycles while VALID → outputs stable and instr_valid held; after stall drops, next imem_addr = pc_out+4.
- redirect = 1, redirect_pc = 0x103, during WAIT; old data returns 2 cycles later → data discarded, instr_valid stays 0, next request addr = 0x100.
- redirect asserted in the same cycle as imem_rvalid → data dropped, next REQ at target; redirect during VALID with stall = 1 → instr_valid = 0 next cycle.
- RESET_PC = 0xFFFFFFFC, first instruction accepted → next imem_addr = 0x00000000; rst asserted in WAIT → all outputs return to reset values and a late rvalid has no effect.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES = 4, memory never responds → fetch_error = 1 after 4 WAIT cycles, imem_req reasserted with the same address.
